// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier.
// The mantissa product is built with a radix-2 shift-add loop, then normalized
// and rounded in five modes. NaN, infinity and zero operands skip the loop and
// complete in one cycle. The flag set matches the divider so the FPU result
// mux can treat both units the same way.
module fp_mul_seq #(
    parameter int W    = 32,
    parameter int M    = 22,
    parameter int E    = 30,
    parameter int BIAS = 127
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [2:0]   round_m,
    output logic [W-1:0] out,
    output logic         busy,
    output logic         done,
    output logic         ov,
    output logic         un,
    output logic         inv,
    output logic         inexact
);
    localparam int FW = M + 1;          // fraction bits
    localparam int MW = M + 2;          // mantissa including hidden one
    localparam int PW = 2 * MW;         // full product width
    localparam int EW = E - M;          // exponent field width
    localparam int XW = EW + 2;         // signed working exponent, never wraps
    localparam int CW = $clog2(MW);

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RZ  = 3'd1;
    localparam logic [2:0] RU  = 3'd2;
    localparam logic [2:0] RD  = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {M{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_OUT} state_t;

    state_t state_q, state_d;

    // operand classification, only meaningful in IDLE
    logic [EW-1:0] e1, e2;
    logic [FW-1:0] f1, f2;
    logic z1, z2, i1, i2, n1, n2, sn1, sn2, spec, s_in;
    logic [W-1:0] sres;
    logic         sinv;

    assign e1   = in1[E:M+1];
    assign e2   = in2[E:M+1];
    assign f1   = in1[M:0];
    assign f2   = in2[M:0];
    assign z1   = (e1 == '0);
    assign z2   = (e2 == '0);
    assign i1   = (e1 == '1) && (f1 == '0);
    assign i2   = (e2 == '1) && (f2 == '0);
    assign n1   = (e1 == '1) && (f1 != '0);
    assign n2   = (e2 == '1) && (f2 != '0);
    assign sn1  = n1 & ~f1[M];
    assign sn2  = n2 & ~f2[M];
    assign s_in = in1[W-1] ^ in2[W-1];
    assign spec = z1 | z2 | i1 | i2 | n1 | n2;

    // forced result for special operands, in priority order
    always_comb begin
        sres = {s_in, {(W-1){1'b0}}};
        sinv = 1'b0;
        if (sn1 | sn2) begin
            sres = QNAN;
            sinv = 1'b1;
        end else if (n1 | n2) begin
            sres = QNAN;
        end else if ((z1 & i2) | (i1 & z2)) begin
            sres = QNAN;
            sinv = 1'b1;
        end else if (i1 | i2) begin
            sres = {s_in, {EW{1'b1}}, {FW{1'b0}}};
        end
    end

    // datapath registers
    logic                 s0_q, spec_q, sinv_q, g_q, st_q, inx_q;
    logic [2:0]           mode_q;
    logic [W-1:0]         sres_q;
    logic [MW-1:0]        a_q, mant_q;
    logic [PW-1:0]        b_q, p_q;
    logic [CW-1:0]        cnt_q;
    logic signed [XW-1:0] ex_q;

    // rounding increment and carry-out
    logic          rinc;
    logic [MW:0]   rsum;
    always_comb begin
        case (mode_q)
            RZ:      rinc = 1'b0;
            RU:      rinc = ~s0_q & (g_q | st_q);
            RD:      rinc = s0_q & (g_q | st_q);
            RNA:     rinc = g_q;
            default: rinc = g_q & (st_q | mant_q[0]);
        endcase
    end
    assign rsum = {1'b0, mant_q} + {{MW{1'b0}}, rinc};

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (act) state_d = spec ? S_OUT : S_MUL;
            S_MUL:   if (cnt_q == CW'(MW - 1)) state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // capture, shift-add loop, normalize and round
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q   <= 1'b0;
            spec_q <= 1'b0;
            sinv_q <= 1'b0;
            sres_q <= '0;
            mode_q <= RNE;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            ex_q   <= '0;
            mant_q <= '0;
            g_q    <= 1'b0;
            st_q   <= 1'b0;
            inx_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (act) begin
                    s0_q   <= s_in;
                    mode_q <= (round_m > RNA) ? RNE : round_m;
                    spec_q <= spec;
                    sres_q <= sres;
                    sinv_q <= sinv;
                    a_q    <= {1'b1, f1};
                    b_q    <= {{MW{1'b0}}, 1'b1, f2};
                    p_q    <= '0;
                    cnt_q  <= '0;
                    ex_q   <= XW'(e1) + XW'(e2) - XW'(BIAS);
                end
                // multiplier shifts right, multiplicand left: same as B<<cnt
                S_MUL: begin
                    if (a_q[0]) p_q <= p_q + b_q;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_NORM: begin
                    if (p_q[PW-1]) begin
                        mant_q <= p_q[PW-1:MW];
                        g_q    <= p_q[MW-1];
                        st_q   <= |p_q[MW-2:0];
                        ex_q   <= ex_q + XW'(1);
                    end else begin
                        mant_q <= p_q[PW-2:MW-1];
                        g_q    <= p_q[MW-2];
                        st_q   <= |p_q[MW-3:0];
                    end
                end
                S_ROUND: begin
                    if (rsum[MW]) begin
                        mant_q <= {1'b1, {(MW-1){1'b0}}};
                        ex_q   <= ex_q + XW'(1);
                    end else begin
                        mant_q <= rsum[MW-1:0];
                    end
                    inx_q <= g_q | st_q;
                end
                default: ;
            endcase
        end
    end

    // result packing and range checks
    logic         ovf, unf, tozero;
    logic [W-1:0] out_q, out_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic         ov_q, ov_d, un_q, un_d, inv_q, inv_d, inx_o_q, inx_o_d;

    assign ovf    = (ex_q >= EXP_MAX);
    assign unf    = ex_q[XW-1] | (ex_q == '0);
    assign tozero = (mode_q == RZ) | ((mode_q == RU) & s0_q) | ((mode_q == RD) & ~s0_q);

    // output next-values: busy tracks the operation, results load in OUT
    always_comb begin
        busy_d  = 1'b1;
        done_d  = 1'b0;
        out_d   = out_q;
        ov_d    = ov_q;
        un_d    = un_q;
        inv_d   = inv_q;
        inx_o_d = inx_o_q;
        case (state_q)
            S_IDLE: busy_d = act;
            S_OUT: begin
                done_d  = 1'b1;
                ov_d    = 1'b0;
                un_d    = 1'b0;
                inv_d   = 1'b0;
                inx_o_d = 1'b0;
                if (spec_q) begin
                    out_d = sres_q;
                    inv_d = sinv_q;
                end else if (ovf) begin
                    out_d   = tozero ? {s0_q, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}}
                                     : {s0_q, {EW{1'b1}}, {FW{1'b0}}};
                    ov_d    = 1'b1;
                    inx_o_d = 1'b1;
                end else if (unf) begin
                    out_d   = {s0_q, {(W-1){1'b0}}};
                    un_d    = 1'b1;
                    inx_o_d = 1'b1;
                end else begin
                    out_d   = {s0_q, ex_q[EW-1:0], mant_q[M:0]};
                    inx_o_d = inx_q;
                end
            end
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            inv_q   <= 1'b0;
            inx_o_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            inv_q   <= inv_d;
            inx_o_q <= inx_o_d;
        end
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ov      = ov_q;
    assign un      = un_q;
    assign inv     = inv_q;
    assign inexact = inx_o_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed cases with known answers, back-to-back,
// abort by reset, and randomized operands against an integer reference model.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        act = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic [2:0]  round_m = '0;
    logic [31:0] out;
    logic        busy, done, ov, un, inv, inexact;

    int checks = 0;
    int errors = 0;

    fp_mul_seq dut (
        .clk(clk), .rst(rst), .act(act), .in1(in1), .in2(in2), .round_m(round_m),
        .out(out), .busy(busy), .done(done), .ov(ov), .un(un), .inv(inv),
        .inexact(inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_spec(input logic [31:0] x);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
    endfunction

    // reference: value-level rules with 64-bit integer arithmetic
    // fl = {ov, un, inv, inexact}
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] rm,
                                  output logic [31:0] r, output logic [3:0] fl);
        int ea, eb, ex, sh;
        bit s, za, zb, ia, ib, na, nb, sa, sb, g, st, inc, tz;
        logic [2:0] m;
        longint unsigned ma, mb, p, mant, rem, half;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        sa = na && !a[22]; sb = nb && !b[22];
        fl = 4'b0000;
        m  = (rm > 3'd4) ? 3'd0 : rm;
        if (sa || sb) begin r = 32'h7FC00000; fl = 4'b0010; end
        else if (na || nb) r = 32'h7FC00000;
        else if ((za && ib) || (ia && zb)) begin r = 32'h7FC00000; fl = 4'b0010; end
        else if (ia || ib) r = {s, 8'hFF, 23'h0};
        else if (za || zb) r = {s, 31'h0};
        else begin
            ma = 64'(a[22:0]) + (64'd1 << 23);
            mb = 64'(b[22:0]) + (64'd1 << 23);
            p  = ma * mb;
            ex = ea + eb - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; ex++; end
            else sh = 23;
            mant = p >> sh;
            rem  = p - (mant << sh);
            half = 64'd1 << (sh - 1);
            g    = (rem >= half);
            st   = ((rem % half) != 0);
            case (m)
                3'd1:    inc = 1'b0;
                3'd2:    inc = !s && (g || st);
                3'd3:    inc = s && (g || st);
                3'd4:    inc = g;
                default: inc = g && (st || mant[0]);
            endcase
            mant = mant + 64'(inc);
            if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; ex++; end
            tz = (m == 3'd1) || (m == 3'd2 && s) || (m == 3'd3 && !s);
            if (ex >= 255) begin
                r  = tz ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0};
                fl = 4'b1001;
            end else if (ex <= 0) begin
                r  = {s, 31'h0};
                fl = 4'b0101;
            end else begin
                r  = {s, 8'(ex), 23'(mant)};
                fl = {3'b000, g || st};
            end
        end
    endfunction

    // one operation from IDLE; expected from constants when use_k, else model
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                         input bit poke, input bit use_k, input logic [31:0] k_out,
                         input logic [3:0] k_fl, input string tag);
        logic [31:0] er;
        logic [3:0]  ef;
        int n, lat;
        bit bsy_ok;
        if (use_k) begin er = k_out; ef = k_fl; end
        else model(a, b, m, er, ef);
        lat = (is_spec(a) || is_spec(b)) ? 1 : 27;
        in1 = a; in2 = b; round_m = m; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        in1 = $urandom; in2 = $urandom; round_m = 3'($urandom);
        n = 0; bsy_ok = 1'b1;
        while (!done && n < 64) begin
            if (!busy) bsy_ok = 1'b0;
            act = (poke && n == 5);
            @(posedge clk); #1;
            n++;
        end
        act = 1'b0;
        if (!busy) bsy_ok = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " busy"}, {31'h0, bsy_ok}, 32'h1);
        chk({tag, " out"}, out, er);
        chk({tag, " flags"}, {28'h0, ov, un, inv, inexact}, {28'h0, ef});
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {31'h0, done}, 32'h0);
    endtask

    int n;
    bit seen;
    logic [31:0] ra, rb, er;
    logic [3:0]  ef;

    initial begin
        #3 rst = 1'b0;
        #1;
        chk("reset out", out, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        chk("reset flags", {28'h0, ov, un, inv, inexact}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(32'h3FC00000, 32'h40000000, 3'd0, 0, 1, 32'h40400000, 4'b0000, "1.5x2");
        do_op(32'h3F800001, 32'h3F800001, 3'd0, 0, 1, 32'h3F800002, 4'b0001, "ulp RNe");
        do_op(32'h3F800001, 32'h3F800001, 3'd2, 0, 1, 32'h3F800003, 4'b0001, "ulp RU");
        do_op(32'h3F800001, 32'h3F800001, 3'd1, 0, 1, 32'h3F800002, 4'b0001, "ulp RZ");
        do_op(32'h7F000000, 32'h7F000000, 3'd0, 0, 1, 32'h7F800000, 4'b1001, "ovf RNe");
        do_op(32'h7F000000, 32'h7F000000, 3'd1, 0, 1, 32'h7F7FFFFF, 4'b1001, "ovf RZ");
        do_op(32'hFF000000, 32'h7F000000, 3'd2, 0, 1, 32'hFF7FFFFF, 4'b1001, "ovf neg RU");
        do_op(32'h00000000, 32'h7F800000, 3'd0, 0, 1, 32'h7FC00000, 4'b0010, "0xinf");
        do_op(32'h7F800001, 32'h3F800000, 3'd0, 0, 1, 32'h7FC00000, 4'b0010, "snan");
        do_op(32'h7FC00000, 32'h3F800000, 3'd0, 0, 1, 32'h7FC00000, 4'b0000, "qnan");
        do_op(32'h00800000, 32'h3F000000, 3'd0, 0, 1, 32'h00000000, 4'b0101, "unf pos");
        do_op(32'h80800000, 32'h3F000000, 3'd0, 0, 1, 32'h80000000, 4'b0101, "unf neg");
        do_op(32'hBF800000, 32'h7F800000, 3'd0, 0, 1, 32'hFF800000, 4'b0000, "-1xinf");
        do_op(32'h3FC00000, 32'h40000000, 3'd0, 1, 1, 32'h40400000, 4'b0000, "act in MUL");

        // back-to-back with act held high
        in1 = 32'h3FC00000; in2 = 32'h40000000; round_m = 3'd0; act = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 64) begin @(posedge clk); #1; n++; end
        chk("b2b latency1", 32'(n), 32'd27);
        chk("b2b out1", out, 32'h40400000);
        in1 = 32'h3F800001; in2 = 32'h3F800001; round_m = 3'd2;
        @(posedge clk); #1;
        act = 1'b0;
        chk("b2b busy kept", {31'h0, busy}, 32'h1);
        chk("b2b done drop", {31'h0, done}, 32'h0);
        n = 0;
        while (!done && n < 64) begin @(posedge clk); #1; n++; end
        chk("b2b latency2", 32'(n), 32'd27);
        chk("b2b out2", out, 32'h3F800003);
        @(posedge clk); #1;

        // abort by reset during MUL
        in1 = 32'h3FC00000; in2 = 32'h40000000; round_m = 3'd0; act = 1'b1;
        @(posedge clk); #1;
        act = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort out", out, 32'h0);
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort done", {31'h0, done}, 32'h0);
        chk("abort flags", {28'h0, ov, un, inv, inexact}, 32'h0);
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        rst = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        chk("abort no done", {31'h0, seen}, 32'h0);
        do_op(32'h3F800000, 32'h3F800000, 3'd0, 0, 1, 32'h3F800000, 4'b0000, "1x1 after rst");

        // randomized operands and modes against the model
        for (int k = 0; k < 40; k++) begin
            ra = $urandom; rb = $urandom;
            case (k % 8)
                1: begin ra[30:23] = 8'($urandom_range(1, 12)); rb[30:23] = 8'($urandom_range(100, 130)); end
                3: ra[30:23] = 8'h00;
                5: rb[30:23] = 8'hFF;
                6: begin ra[30:23] = 8'($urandom_range(120, 134)); rb[30:23] = 8'($urandom_range(120, 134)); end
                7: begin ra[30:23] = 8'hFF; ra[22] = 1'($urandom); end
                default: ;
            endcase
            do_op(ra, rb, 3'($urandom_range(0, 7)), (k % 5 == 2), 0, 32'h0, 4'h0, "random");
        end

        // model spot check of a single directed value via the DUT path
        model(32'h40400000, 32'h40400000, 3'd0, er, ef);
        do_op(32'h40400000, 32'h40400000, 3'd0, 0, 1, 32'h41100000, 4'b0000, "3x3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
